idex_stage: RTL and testbench

- ID/EX pipeline register and operand-select/forwarding stage of the RV32I core.
- Captures decoded fields each cycle and drives `alu_a`, `alu_b` and the 4-bit ALU control directly into the ALU.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports stall (hold) and flush (bubble).

---
 rtl/idex_stage.sv | 158 +++++++++++++++
 tb/tb_idex_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register with RAW forwarding and ALU operand select.
// Define IDEX_LOADUSE_EN to enable load-use hazard detection.
module idex_stage #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid_i,
   input  logic [XLEN-1:0]  id_pc_i,
   input  logic [XLEN-1:0]  id_rs1_data_i,
   input  logic [XLEN-1:0]  id_rs2_data_i,
   input  logic [RF_AW-1:0] id_rs1_addr_i,
   input  logic [RF_AW-1:0] id_rs2_addr_i,
   input  logic [RF_AW-1:0] id_rd_addr_i,
   input  logic [XLEN-1:0]  id_imm_i,
   input  logic [1:0]       id_asel_i,
   input  logic [1:0]       id_bsel_i,
   input  logic [3:0]       id_aluctrl_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             exmem_regwrite_i,
   input  logic [RF_AW-1:0] exmem_rd_i,
   input  logic [XLEN-1:0]  exmem_result_i,
   input  logic             memwb_regwrite_i,
   input  logic [RF_AW-1:0] memwb_rd_i,
   input  logic [XLEN-1:0]  memwb_result_i,
   output logic [XLEN-1:0]  alu_a_o,
   output logic [XLEN-1:0]  alu_b_o,
   output logic [3:0]       aluctrl_ctrl_o,
   output logic [XLEN-1:0]  store_data_o,
   output logic [RF_AW-1:0] ex_rd_o,
   output logic             ex_regwrite_o,
   output logic             ex_memread_o,
   output logic             ex_valid_o,
   output logic [XLEN-1:0]  ex_pc_o,
   output logic             load_use_stall_o
);

   logic             r_valid;
   logic             r_regwrite;
   logic [3:0]       r_ctrl;
   logic [RF_AW-1:0] r_rd;
   logic [RF_AW-1:0] r_rs1;
   logic [RF_AW-1:0] r_rs2;
   logic [1:0]       r_asel;
   logic [1:0]       r_bsel;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_rs1_data;
   logic [XLEN-1:0]  r_rs2_data;
   logic [XLEN-1:0]  r_imm;

   logic             w_load;
   logic [XLEN-1:0]  w_fwd_a;
   logic [XLEN-1:0]  w_fwd_b;

   // flush must win over stall, so it always opens the register
   assign w_load = flush_i | ~stall_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_ctrl     <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_asel     <= '0;
         r_bsel     <= '0;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
      end else if (w_load) begin
         r_valid    <= id_valid_i & ~flush_i;
         r_regwrite <= id_regwrite_i & ~flush_i;
         r_ctrl     <= flush_i ? 4'b0000 : id_aluctrl_i;
         r_rd       <= flush_i ? '0 : id_rd_addr_i;
         r_rs1      <= id_rs1_addr_i;
         r_rs2      <= id_rs2_addr_i;
         r_asel     <= id_asel_i;
         r_bsel     <= id_bsel_i;
         r_pc       <= id_pc_i;
         r_rs1_data <= id_rs1_data_i;
         r_rs2_data <= id_rs2_data_i;
         r_imm      <= id_imm_i;
      end
   end

`ifdef IDEX_LOADUSE_EN
   logic r_memread;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_memread <= 1'b0;
      end else if (w_load) begin
         r_memread <= id_memread_i & ~flush_i;
      end
   end

   assign ex_memread_o     = r_memread & r_valid;
   assign load_use_stall_o = r_valid & r_memread & (r_rd != '0) &
                             ((r_rd == id_rs1_addr_i) |
                              (r_rd == id_rs2_addr_i)) &
                             id_valid_i;
`else
   logic w_unused;

   assign w_unused         = id_memread_i;
   assign ex_memread_o     = 1'b0;
   assign load_use_stall_o = 1'b0;
`endif

   // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded
   always_comb begin
      w_fwd_a = r_rs1_data;
      if (exmem_regwrite_i && exmem_rd_i != '0 && exmem_rd_i == r_rs1)
         w_fwd_a = exmem_result_i;
      else if (memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == r_rs1)
         w_fwd_a = memwb_result_i;
   end

   always_comb begin
      w_fwd_b = r_rs2_data;
      if (exmem_regwrite_i && exmem_rd_i != '0 && exmem_rd_i == r_rs2)
         w_fwd_b = exmem_result_i;
      else if (memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == r_rs2)
         w_fwd_b = memwb_result_i;
   end

   always_comb begin
      alu_a_o = w_fwd_a;
      unique case (r_asel)
         2'b01:   alu_a_o = r_pc;
         2'b10:   alu_a_o = '0;
         default: alu_a_o = w_fwd_a;
      endcase
   end

   always_comb begin
      alu_b_o = w_fwd_b;
      unique case (r_bsel)
         2'b01:   alu_b_o = r_imm;
         2'b10:   alu_b_o = XLEN'(4);
         default: alu_b_o = w_fwd_b;
      endcase
   end

   assign store_data_o   = w_fwd_b;
   assign aluctrl_ctrl_o = r_ctrl;
   assign ex_rd_o        = r_rd;
   assign ex_regwrite_o  = r_regwrite & r_valid;
   assign ex_valid_o     = r_valid;
   assign ex_pc_o        = r_pc;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: vector table, directed corners, random vs model.
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic [31:0] id_rs1_data_i;
   logic [31:0] id_rs2_data_i;
   logic [4:0]  id_rs1_addr_i;
   logic [4:0]  id_rs2_addr_i;
   logic [4:0]  id_rd_addr_i;
   logic [31:0] id_imm_i;
   logic [1:0]  id_asel_i;
   logic [1:0]  id_bsel_i;
   logic [3:0]  id_aluctrl_i;
   logic        id_regwrite_i;
   logic        id_memread_i;
   logic        stall_i;
   logic        flush_i;
   logic        exmem_regwrite_i;
   logic [4:0]  exmem_rd_i;
   logic [31:0] exmem_result_i;
   logic        memwb_regwrite_i;
   logic [4:0]  memwb_rd_i;
   logic [31:0] memwb_result_i;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [3:0]  aluctrl_ctrl_o;
   logic [31:0] store_data_o;
   logic [4:0]  ex_rd_o;
   logic        ex_regwrite_o;
   logic        ex_memread_o;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic        load_use_stall_o;

`ifdef IDEX_LOADUSE_EN
   localparam bit LU = 1'b1;
`else
   localparam bit LU = 1'b0;
`endif

   idex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
      .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_rd_addr_i(id_rd_addr_i), .id_imm_i(id_imm_i),
      .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i),
      .id_aluctrl_i(id_aluctrl_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .stall_i(stall_i), .flush_i(flush_i),
      .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
      .exmem_result_i(exmem_result_i), .memwb_regwrite_i(memwb_regwrite_i),
      .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .aluctrl_ctrl_o(aluctrl_ctrl_o),
      .store_data_o(store_data_o), .ex_rd_o(ex_rd_o),
      .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
      .load_use_stall_o(load_use_stall_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // What the stage should be holding after each edge
   typedef struct packed {
      logic        v;
      logic        rw;
      logic        mr;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [1:0]  as;
      logic [1:0]  bs;
      logic [31:0] pc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
   } mdl_t;

   mdl_t m = '0;

   typedef struct {
      logic [4:0]  rs1;
      logic [31:0] d1;
      logic [4:0]  rs2;
      logic [31:0] d2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [1:0]  as;
      logic [1:0]  bs;
      logic        ew;
      logic [4:0]  erd;
      logic [31:0] eres;
      logic        mw;
      logic [4:0]  mrd;
      logic [31:0] mres;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] es;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic mdl_t cap();
      mdl_t c;
      c.v    = id_valid_i;
      c.rw   = id_regwrite_i;
      c.mr   = id_memread_i;
      c.ctrl = id_aluctrl_i;
      c.rd   = id_rd_addr_i;
      c.rs1  = id_rs1_addr_i;
      c.rs2  = id_rs2_addr_i;
      c.as   = id_asel_i;
      c.bs   = id_bsel_i;
      c.pc   = id_pc_i;
      c.d1   = id_rs1_data_i;
      c.d2   = id_rs2_data_i;
      c.imm  = id_imm_i;
      return c;
   endfunction

   task automatic tick();
      mdl_t nx;
      if (!rst_n) nx = '0;
      else if (flush_i) begin
         nx      = cap();
         nx.v    = 1'b0;
         nx.rw   = 1'b0;
         nx.mr   = 1'b0;
         nx.ctrl = 4'h0;
         nx.rd   = 5'd0;
      end else if (stall_i) nx = m;
      else nx = cap();
      @(posedge clk);
      #1;
      m = nx;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] a,
                                       input logic [31:0] d);
      if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == a)
         return exmem_result_i;
      if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == a)
         return memwb_result_i;
      return d;
   endfunction

   task automatic chk_all();
      logic [31:0] a, b, s;
      logic        lu;
      #1;
      s = fwd(m.rs2, m.d2);
      a = (m.as == 2'd1) ? m.pc : (m.as == 2'd2) ? 32'd0 : fwd(m.rs1, m.d1);
      b = (m.bs == 2'd1) ? m.imm : (m.bs == 2'd2) ? 32'd4 : s;
      lu = LU && m.v && m.mr && m.rd != 0 && id_valid_i &&
           (m.rd == id_rs1_addr_i || m.rd == id_rs2_addr_i);
      chk("rnd_alu_a", alu_a_o, a);
      chk("rnd_alu_b", alu_b_o, b);
      chk("rnd_store", store_data_o, s);
      chk("rnd_ctrl", 32'(aluctrl_ctrl_o), 32'(m.ctrl));
      chk("rnd_rd", 32'(ex_rd_o), 32'(m.rd));
      chk("rnd_valid", 32'(ex_valid_o), 32'(m.v));
      chk("rnd_regwrite", 32'(ex_regwrite_o), 32'(m.rw & m.v));
      chk("rnd_memread", 32'(ex_memread_o), 32'(LU & m.mr & m.v));
      chk("rnd_pc", ex_pc_o, m.pc);
      chk("rnd_loaduse", 32'(load_use_stall_o), 32'(lu));
   endtask

   task automatic rand_id();
      id_valid_i    = 1'($urandom);
      id_pc_i       = $urandom;
      id_rs1_data_i = $urandom;
      id_rs2_data_i = $urandom;
      id_rs1_addr_i = 5'($urandom_range(0, 7));
      id_rs2_addr_i = 5'($urandom_range(0, 7));
      id_rd_addr_i  = 5'($urandom_range(0, 7));
      id_imm_i      = $urandom;
      id_asel_i     = 2'($urandom);
      id_bsel_i     = 2'($urandom);
      id_aluctrl_i  = 4'($urandom);
      id_regwrite_i = 1'($urandom);
      id_memread_i  = 1'($urandom);
   endtask

   task automatic rand_fwd();
      exmem_regwrite_i = 1'($urandom);
      exmem_rd_i       = 5'($urandom_range(0, 7));
      exmem_result_i   = $urandom;
      memwb_regwrite_i = 1'($urandom);
      memwb_rd_i       = 5'($urandom_range(0, 7));
      memwb_result_i   = $urandom;
   endtask

   task automatic zero_fwd();
      exmem_regwrite_i = 1'b0;
      exmem_rd_i       = 5'd0;
      exmem_result_i   = 32'd0;
      memwb_regwrite_i = 1'b0;
      memwb_rd_i       = 5'd0;
      memwb_result_i   = 32'd0;
   endtask

   initial begin
      vt[0] = '{5'd5, 32'h11, 5'd3, 32'h22, 32'h0, 32'h0, 2'd0, 2'd0,
                1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB,
                32'hAA, 32'h22, 32'h22};
      vt[1] = '{5'd5, 32'h11, 5'd3, 32'h22, 32'h0, 32'h0, 2'd0, 2'd0,
                1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB,
                32'hBB, 32'h22, 32'h22};
      vt[2] = '{5'd5, 32'h11, 5'd3, 32'h22, 32'h0, 32'h0, 2'd0, 2'd0,
                1'b0, 5'd5, 32'hAA, 1'b0, 5'd5, 32'hBB,
                32'h11, 32'h22, 32'h22};
      vt[3] = '{5'd1, 32'h1, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0,
                1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,
                32'h1, 32'h0, 32'h0};
      vt[4] = '{5'd2, 32'h9, 5'd4, 32'h44, 32'h100, 32'hFFFFFFF0, 2'd1, 2'd1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h100, 32'hFFFFFFF0, 32'h44};
      vt[5] = '{5'd2, 32'h9, 5'd4, 32'h44, 32'h100, 32'hFFFFFFF0, 2'd2, 2'd2,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h4, 32'h44};
      vt[6] = '{5'd7, 32'h1, 5'd6, 32'h66, 32'h0, 32'h20, 2'd0, 2'd1,
                1'b1, 5'd7, 32'h88, 1'b1, 5'd6, 32'h77,
                32'h88, 32'h20, 32'h77};
      vt[7] = '{5'd5, 32'h55, 5'd5, 32'h56, 32'h0, 32'h0, 2'd3, 2'd3,
                1'b0, 5'd5, 32'h1, 1'b1, 5'd5, 32'h99,
                32'h99, 32'h99, 32'h99};

      rst_n   = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
      zero_fwd();
      rand_id();

      // reset held two cycles while decode presents garbage
      tick();
      rand_id();
      stall_i = 1'b1;
      flush_i = 1'b1;
      tick();
      chk("rst_valid", 32'(ex_valid_o), 32'd0);
      chk("rst_ctrl", 32'(aluctrl_ctrl_o), 32'd0);
      chk("rst_alu_a", alu_a_o, 32'd0);
      chk("rst_alu_b", alu_b_o, 32'd0);
      chk("rst_regwrite", 32'(ex_regwrite_o), 32'd0);
      chk("rst_memread", 32'(ex_memread_o), 32'd0);
      chk("rst_store", store_data_o, 32'd0);
      chk("rst_pc", ex_pc_o, 32'd0);
      chk("rst_rd", 32'(ex_rd_o), 32'd0);
      rst_n   = 1'b1;
      stall_i = 1'b0;
      flush_i = 1'b0;

      foreach (vt[i]) begin
         zero_fwd();
         id_valid_i    = 1'b1;
         id_regwrite_i = 1'b0;
         id_memread_i  = 1'b0;
         id_aluctrl_i  = 4'h0;
         id_rd_addr_i  = 5'd0;
         id_rs1_addr_i = vt[i].rs1;
         id_rs1_data_i = vt[i].d1;
         id_rs2_addr_i = vt[i].rs2;
         id_rs2_data_i = vt[i].d2;
         id_pc_i       = vt[i].pc;
         id_imm_i      = vt[i].imm;
         id_asel_i     = vt[i].as;
         id_bsel_i     = vt[i].bs;
         tick();
         exmem_regwrite_i = vt[i].ew;
         exmem_rd_i       = vt[i].erd;
         exmem_result_i   = vt[i].eres;
         memwb_regwrite_i = vt[i].mw;
         memwb_rd_i       = vt[i].mrd;
         memwb_result_i   = vt[i].mres;
         #1;
         chk($sformatf("vec%0d_alu_a", i), alu_a_o, vt[i].ea);
         chk($sformatf("vec%0d_alu_b", i), alu_b_o, vt[i].eb);
         chk($sformatf("vec%0d_store", i), store_data_o, vt[i].es);
      end

      // instruction A, then stall with decode changing underneath
      zero_fwd();
      id_valid_i    = 1'b1;
      id_regwrite_i = 1'b1;
      id_memread_i  = 1'b0;
      id_aluctrl_i  = 4'h5;
      id_rd_addr_i  = 5'd9;
      id_pc_i       = 32'h200;
      id_rs1_addr_i = 5'd3;
      id_rs1_data_i = 32'h1234;
      id_rs2_addr_i = 5'd0;
      id_rs2_data_i = 32'h0;
      id_imm_i      = 32'h10;
      id_asel_i     = 2'd0;
      id_bsel_i     = 2'd1;
      tick();
      chk("a_ctrl", 32'(aluctrl_ctrl_o), 32'h5);
      chk("a_alu_a", alu_a_o, 32'h1234);
      for (int k = 0; k < 3; k++) begin
         rand_id();
         stall_i = 1'b1;
         tick();
         chk("stall_pc", ex_pc_o, 32'h200);
         chk("stall_alu_a", alu_a_o, 32'h1234);
         chk("stall_alu_b", alu_b_o, 32'h10);
         chk("stall_ctrl", 32'(aluctrl_ctrl_o), 32'h5);
         chk("stall_rd", 32'(ex_rd_o), 32'd9);
         chk("stall_valid", 32'(ex_valid_o), 32'd1);
         chk("stall_regwrite", 32'(ex_regwrite_o), 32'd1);
      end
      rand_id();
      id_valid_i    = 1'b1;
      id_regwrite_i = 1'b1;
      id_aluctrl_i  = 4'hA;
      flush_i       = 1'b1;
      tick();
      chk("flush_valid", 32'(ex_valid_o), 32'd0);
      chk("flush_regwrite", 32'(ex_regwrite_o), 32'd0);
      chk("flush_ctrl", 32'(aluctrl_ctrl_o), 32'd0);
      chk("flush_rd", 32'(ex_rd_o), 32'd0);
      stall_i = 1'b0;
      flush_i = 1'b0;

      // load with rd=7 followed by a consumer of x7
      id_valid_i    = 1'b1;
      id_memread_i  = 1'b1;
      id_regwrite_i = 1'b1;
      id_rd_addr_i  = 5'd7;
      tick();
      id_rs1_addr_i = 5'd1;
      id_rs2_addr_i = 5'd7;
      id_valid_i    = 1'b1;
      #1;
      chk("lu_hit", 32'(load_use_stall_o), 32'(LU));
      chk("lu_memread", 32'(ex_memread_o), 32'(LU));
      id_valid_i = 1'b0;
      #1;
      chk("lu_idle", 32'(load_use_stall_o), 32'd0);
      id_valid_i   = 1'b1;
      id_rd_addr_i = 5'd0;
      tick();
      id_rs1_addr_i = 5'd0;
      id_rs2_addr_i = 5'd0;
      #1;
      chk("lu_x0", 32'(load_use_stall_o), 32'd0);

      for (int k = 0; k < 400; k++) begin
         rand_id();
         rst_n   = ($urandom_range(0, 49) != 0);
         stall_i = ($urandom_range(0, 4) == 0);
         flush_i = ($urandom_range(0, 6) == 0);
         tick();
         rand_id();
         rand_fwd();
         chk_all();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
